baud_tick_gen_prog: RTL and testbench

//   Runtime-programmable fractional baud tick generator for the UART comm path.

---
 rtl/baud_tick_gen_prog.sv | 124 ++++++++++++
 tb/tb_baud_tick_gen_prog.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/baud_tick_gen_prog.sv
// Runtime-programmable fractional baud tick generator.
// A phase accumulator adds a programmable increment every enabled cycle; its carry
// produces the oversample tick, and every OVERSAMPLE carries produce a bit tick.
// New increments arrive over a valid/ready handshake and, while running, are held
// until the next bit boundary so a rate change never splits a bit period.
module baud_tick_gen_prog #(
    parameter int unsigned ACC_WIDTH   = 24,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DEFAULT_INC = 618475
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 resync,
    input  logic                 cfg_valid,
    input  logic [ACC_WIDTH-1:0] cfg_inc,
    output logic                 cfg_ready,
    output logic                 os_tick,
    output logic                 bit_tick
);

    localparam int unsigned CntW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [ACC_WIDTH-1:0] IncRst  = ACC_WIDTH'(DEFAULT_INC);
    localparam logic [CntW-1:0]      CntLast = CntW'(OVERSAMPLE - 1);
    localparam logic [CntW-1:0]      CntHalf = CntW'(OVERSAMPLE / 2);

    // Architectural state
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] inc_q, inc_d;
    logic [ACC_WIDTH-1:0] pend_inc_q, pend_inc_d;
    logic                 pend_q, pend_d;
    logic                 os_tick_q, os_tick_d;
    logic                 bit_tick_q, bit_tick_d;

    // Datapath helpers
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic                 cfg_xfer;
    logic                 bit_edge;

    // Phase add: one extra bit captures the carry that marks an oversample tick.
    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, inc_q};
        carry    = sum[ACC_WIDTH];
        cfg_xfer = cfg_valid && !pend_q;
        bit_edge = carry && (cnt_q == CntLast);
    end

    // Next-state: priority is enable=0, then resync, then normal run.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        inc_d      = inc_q;
        pend_inc_d = pend_inc_q;
        pend_d     = pend_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;

        if (!enable || resync) begin
            // Both stop phase accumulation, so a held increment is safe to apply now.
            acc_d = '0;
            cnt_d = enable ? CntHalf : '0;
            if (pend_q) begin
                inc_d  = pend_inc_q;
                pend_d = 1'b0;
            end
            // cfg_xfer implies no pending value, so this never races the apply above.
            if (cfg_xfer) begin
                inc_d = cfg_inc;
            end
        end else begin
            acc_d     = sum[ACC_WIDTH-1:0];
            os_tick_d = carry;
            if (carry) begin
                if (bit_edge) begin
                    cnt_d      = '0;
                    bit_tick_d = 1'b1;
                    // Swap rate at the bit boundary; this edge's add already used the old one.
                    if (pend_q) begin
                        inc_d  = pend_inc_q;
                        pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            if (cfg_xfer) begin
                pend_inc_d = cfg_inc;
                pend_d     = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            inc_q      <= IncRst;
            pend_inc_q <= '0;
            pend_q     <= 1'b0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            inc_q      <= inc_d;
            pend_inc_q <= pend_inc_d;
            pend_q     <= pend_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    // Outputs come straight from flops; ready is the inverse of the pending flag.
    always_comb begin
        os_tick   = os_tick_q;
        bit_tick  = bit_tick_q;
        cfg_ready = !pend_q;
    end

endmodule

// File: tb/tb_baud_tick_gen_prog.sv
// Self-checking bench for baud_tick_gen_prog (ACC_WIDTH=8, OVERSAMPLE=4, DEFAULT_INC=64).
// The reference tracks total phase since the last restart as a plain integer and counts
// whole-tick crossings; held rate changes live in a queue.
module tb_baud_tick_gen_prog;

    localparam int AW   = 8;
    localparam int OS   = 4;
    localparam int DINC = 64;
    localparam int UNIT = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          resync;
    logic          cfg_valid;
    logic [AW-1:0] cfg_inc;
    logic          cfg_ready;
    logic          os_tick;
    logic          bit_tick;

    always #5 clk = ~clk;

    baud_tick_gen_prog #(
        .ACC_WIDTH  (AW),
        .OVERSAMPLE (OS),
        .DEFAULT_INC(DINC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .resync   (resync),
        .cfg_valid(cfg_valid),
        .cfg_inc  (cfg_inc),
        .cfg_ready(cfg_ready),
        .os_tick  (os_tick),
        .bit_tick (bit_tick)
    );

    int total = 0;
    int bad   = 0;
    int os_cnt;
    int bit_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model
    longint m_phase;
    int     m_os_in_bit;
    int     m_rate;
    int     m_pend[$];
    bit     m_os;
    bit     m_bit;

    function automatic void model_reset();
        m_phase     = 0;
        m_os_in_bit = 0;
        m_rate      = DINC;
        m_pend.delete();
        m_os        = 1'b0;
        m_bit       = 1'b0;
    endfunction

    function automatic void model_step(input bit en, input bit rs, input bit cv, input int ci);
        bit     take;
        longint nxt;
        take = cv && (m_pend.size() == 0);
        if (!en || rs) begin
            m_phase     = 0;
            m_os_in_bit = en ? OS / 2 : 0;
            m_os        = 1'b0;
            m_bit       = 1'b0;
            if (m_pend.size() != 0) m_rate = m_pend.pop_front();
            if (take) m_rate = ci;
        end else begin
            nxt     = m_phase + m_rate;
            m_os    = (nxt / UNIT) != (m_phase / UNIT);
            m_phase = nxt;
            m_bit   = 1'b0;
            if (m_os) begin
                m_os_in_bit++;
                if (m_os_in_bit == OS) begin
                    m_os_in_bit = 0;
                    m_bit       = 1'b1;
                    if (m_pend.size() != 0) m_rate = m_pend.pop_front();
                end
            end
            if (take) m_pend.push_back(ci);
        end
    endfunction

    // One clock: drive, advance model on the edge, compare 1 time unit later.
    task automatic cycle(input bit en, input bit rs, input bit cv, input int ci, input string tag);
        enable    = en;
        resync    = rs;
        cfg_valid = cv;
        cfg_inc   = AW'(ci);
        @(posedge clk);
        model_step(en, rs, cv, ci);
        #1;
        check_eq({tag, "_os"}, os_tick, m_os);
        check_eq({tag, "_bit"}, bit_tick, m_bit);
        check_eq({tag, "_rdy"}, cfg_ready, (m_pend.size() == 0));
        os_cnt  += os_tick;
        bit_cnt += bit_tick;
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        resync    = 1'b0;
        cfg_valid = 1'b0;
        cfg_inc   = '0;
        model_reset();
        #12;
        check_eq("rst_os", os_tick, 0);
        check_eq("rst_bit", bit_tick, 0);
        check_eq("rst_rdy", cfg_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: default rate, os every 4 edges, bit every 16
        os_cnt = 0; bit_cnt = 0;
        repeat (32) cycle(1, 0, 0, 0, "t1");
        check_eq("t1_os_count", os_cnt, 8);
        check_eq("t1_bit_count", bit_cnt, 2);

        // 2: inc=96 loaded while disabled, 800 enabled edges
        cycle(0, 0, 1, 96, "t2cfg");
        os_cnt = 0; bit_cnt = 0;
        repeat (800) cycle(1, 0, 0, 0, "t2");
        check_eq("t2_os_count", os_cnt, 300);
        check_eq("t2_bit_count", bit_cnt, 75);

        // 3: mid-bit rate change held until the bit boundary
        cycle(0, 0, 1, 64, "t3cfg");
        repeat (6) cycle(1, 0, 0, 0, "t3");
        cycle(1, 0, 1, 128, "t3w");
        check_eq("t3_rdy_low", cfg_ready, 0);
        cycle(1, 0, 1, 200, "t3w2");
        check_eq("t3_rdy_still_low", cfg_ready, 0);
        for (int i = 0; i < 40 && !bit_tick; i++) cycle(1, 0, 0, 0, "t3wait");
        check_eq("t3_bit_seen", bit_tick, 1);
        cycle(1, 0, 0, 0, "t3post");
        check_eq("t3_rdy_back", cfg_ready, 1);
        os_cnt = 0; bit_cnt = 0;
        repeat (16) cycle(1, 0, 0, 0, "t3rate");
        check_eq("t3_os_count", os_cnt, 8);

        // 4: resync to mid-bit
        repeat (3) cycle(1, 0, 0, 0, "t4");
        cycle(1, 1, 0, 0, "t4rs");
        check_eq("t4_rs_os", os_tick, 0);
        check_eq("t4_rs_bit", bit_tick, 0);
        os_cnt = 0; bit_cnt = 0;
        for (int i = 0; i < 60 && bit_cnt == 0; i++) cycle(1, 0, 0, 0, "t4a");
        check_eq("t4_first_bit_os", os_cnt, 2);
        os_cnt = 0; bit_cnt = 0;
        for (int i = 0; i < 60 && bit_cnt == 0; i++) cycle(1, 0, 0, 0, "t4b");
        check_eq("t4_next_bit_os", os_cnt, 4);

        // 5: one-cycle disable behaves like a fresh start
        repeat (3) cycle(1, 0, 0, 0, "t5");
        cycle(0, 0, 0, 0, "t5off");
        check_eq("t5_off_os", os_tick, 0);
        check_eq("t5_off_bit", bit_tick, 0);
        os_cnt = 0; bit_cnt = 0;
        repeat (16) cycle(1, 0, 0, 0, "t5on");
        check_eq("t5_os_count", os_cnt, 8);
        check_eq("t5_bit_count", bit_cnt, 2);

        // Random mix of enable, resync and configuration traffic
        for (int i = 0; i < 3000; i++) begin
            bit rs_b, en_b, cv_b;
            int ci_v;
            en_b = ($urandom_range(0, 19) != 0);
            rs_b = ($urandom_range(0, 29) == 0);
            cv_b = ($urandom_range(0, 3) == 0);
            ci_v = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
            cycle(en_b, rs_b, cv_b, ci_v, "rnd");
        end

        // 6: async reset mid-run with a pending increment
        cycle(0, 0, 1, 64, "t6cfg");
        repeat (3) cycle(1, 0, 0, 0, "t6");
        cycle(1, 0, 1, 32, "t6w");
        check_eq("t6_pre_os", os_tick, 1);
        check_eq("t6_pre_rdy", cfg_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_os", os_tick, 0);
        check_eq("t6_rst_bit", bit_tick, 0);
        check_eq("t6_rst_rdy", cfg_ready, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        os_cnt = 0; bit_cnt = 0;
        repeat (16) cycle(1, 0, 0, 0, "t6run");
        check_eq("t6_os_count", os_cnt, 4);
        check_eq("t6_bit_count", bit_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
